// File: rtl/debounce_sync.sv
// debounce_sync: two-flop synchronizer followed by a four-state debounce FSM.
// A new input level is accepted only after DEBOUNCE_CYCLES consecutive
// synchronized samples agree; any opposite sample restarts the count.
// Outputs the clean level plus one-cycle rise/fall strobes and a busy flag.
module debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit INIT_LEVEL      = 1'b0,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic a_clean,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        ST_LOW    = 2'b00,
        ST_WAIT_H = 2'b01,
        ST_HIGH   = 2'b10,
        ST_WAIT_L = 2'b11
    } state_t;

    // Last count value of the stability window; reaching it on an agreeing
    // sample completes the N-sample run.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam state_t           ST_RESET = INIT_LEVEL ? ST_HIGH : ST_LOW;

    logic             s1;
    logic             s2;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             rise_nxt;
    logic             fall_nxt;

    // Two-flop synchronizer: only s2 is considered safe to use in the FSM.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others (s2 gets old s1, not din).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= INIT_LEVEL;
            s2 <= INIT_LEVEL;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // State, run-length counter and strobe registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RESET;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    // Next-state, counter and strobe decode from the synchronized sample.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_nxt = ST_LOW;
        cnt_nxt   = '0;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            ST_LOW: begin
                if (s2) begin
                    state_nxt = ST_WAIT_H;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    state_nxt = ST_LOW;
                end
            end
            ST_WAIT_H: begin
                if (!s2) begin
                    state_nxt = ST_LOW;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_HIGH;
                    rise_nxt  = 1'b1;
                end else begin
                    state_nxt = ST_WAIT_H;
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!s2) begin
                    state_nxt = ST_WAIT_L;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    state_nxt = ST_HIGH;
                end
            end
            ST_WAIT_L: begin
                if (s2) begin
                    state_nxt = ST_HIGH;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_LOW;
                    fall_nxt  = 1'b1;
                end else begin
                    state_nxt = ST_WAIT_L;
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_LOW;
            end
        endcase
    end

    // Level and busy are decoded straight from the state register.
    always_comb begin
        a_clean = (state == ST_HIGH) || (state == ST_WAIT_L);
        busy    = (state == ST_WAIT_H) || (state == ST_WAIT_L);
    end

endmodule

// File: tb/tb_debounce_sync.sv
// Directed self-checking bench for debounce_sync with N=4, INIT_LEVEL=0.
// With din changed just after edge 0, the FSM sees it at edge 3, busy is
// high on edges 3..5, and level plus strobe change on edge 6.
module tb_debounce_sync;

    logic clk;
    logic reset_n;
    logic din;
    logic a_clean;
    logic rise;
    logic fall;
    logic busy;

    int checks = 0;
    int errors = 0;

    debounce_sync #(
        .DEBOUNCE_CYCLES(4),
        .INIT_LEVEL     (1'b0),
        .CNT_W          (16)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (din),
        .a_clean(a_clean),
        .rise   (rise),
        .fall   (fall),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic ea, input logic er,
                              input logic ef, input logic eb);
        check({tag, "_a_clean"}, 32'(a_clean), 32'(ea));
        check({tag, "_rise"},    32'(rise),    32'(er));
        check({tag, "_fall"},    32'(fall),    32'(ef));
        check({tag, "_busy"},    32'(busy),    32'(eb));
    endtask

    // Drive a new level held steady and check edges 1..7 against the
    // hand-derived timeline: busy on 3..5, change plus strobe on 6.
    task automatic settle(input string tag, input logic level);
        din = level;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check_outs($sformatf("%s_e%0d", tag, e),
                       (e >= 6) ? level : ~level,
                       level && (e == 6),
                       !level && (e == 6),
                       (e >= 3) && (e <= 5));
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_outs("reset_async", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_outs("reset_held", 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic level;
        int   cycles;
        int   run;

        // 1: reset with din=1, then release with din held high.
        din     = 1'b1;
        reset_n = 1'b0;
        #1;
        do_reset();
        settle("t1_rise", 1'b1);

        // 4: fall from HIGH, then a 0,1 sequence back to HIGH.
        settle("t4_fall", 1'b0);
        settle("t4_rise", 1'b1);
        settle("t4_fall2", 1'b0);

        // 2: plain rise from LOW.
        settle("t2_rise", 1'b1);
        settle("t2_back", 1'b0);

        // 3: bounce 1,1,0 then 1 held; final change seen before edge 4.
        din = 1'b1;
        tick(); check_outs("t3_e1", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); check_outs("t3_e2", 1'b0, 1'b0, 1'b0, 1'b0);
        din = 1'b0;
        tick(); check_outs("t3_e3", 1'b0, 1'b0, 1'b0, 1'b1);
        din = 1'b1;
        tick(); check_outs("t3_e4", 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); check_outs("t3_e5", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); check_outs("t3_e6", 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); check_outs("t3_e7", 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); check_outs("t3_e8", 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); check_outs("t3_e9", 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); check_outs("t3_e10", 1'b1, 1'b0, 1'b0, 1'b0);
        settle("t3_back", 1'b0);

        // 5: reset mid WAIT_H (cnt=2 after edge 4), then full recount.
        din = 1'b1;
        for (int e = 1; e <= 4; e++) tick();
        check_outs("t5_waiting", 1'b0, 1'b0, 1'b0, 1'b1);
        do_reset();
        settle("t5_recount", 1'b1);

        // 6: din toggles with runs of 1..3 cycles; nothing may change.
        level  = a_clean;
        din    = level;
        cycles = 0;
        while (cycles < 1000) begin
            din = ~din;
            run = $urandom_range(3, 1);
            for (int i = 0; i < run; i++) begin
                tick();
                cycles++;
                check("t6_level", 32'(a_clean), 32'(level));
                check("t6_strobes", 32'({rise, fall}), 32'b0);
            end
        end
        din = level;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t6_flush_level", 32'(a_clean), 32'(level));
            check("t6_flush_strobes", 32'({rise, fall}), 32'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
